// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit: the fetch FSM state
// encoding, the NOP instruction word shown to the decoder when nothing valid
// is held, the default reset fetch address, and a word-alignment helper.
// -----------------------------------------------------------------------------
package fetch_pkg;

   // Fetch FSM states; at most one memory request is outstanding in any state.
   typedef enum logic [2:0] {
      ST_BOOT  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DROP  = 3'd4
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_1000;
   localparam logic [31:0] PC_STEP          = 32'd4;

   // Force an address onto a 32-bit word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program counter register with a redirect / increment / hold mux.
// A redirect always wins over an increment and loads a word-aligned address.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset (pc -> RESET_PC)
//   redirect_i     in   load redirect_pc_i (bits [1:0] cleared)
//   redirect_pc_i  in   redirect target address
//   incr_i         in   advance pc by one word (wraps modulo 2^32)
//   pc_o           out  current pc (registered)
// -----------------------------------------------------------------------------
module pc_reg
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        incr_i,
   output logic [31:0] pc_o
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;

   // Next-pc select: redirect has priority, then sequential increment.
   always_comb begin
      pc_d = pc_q;
      if (redirect_i) begin
         pc_d = word_align(redirect_pc_i);
      end else if (incr_i) begin
         pc_d = pc_q + PC_STEP;
      end else begin
         pc_d = pc_q;
      end
   end

   // PC state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Single-outstanding-request instruction fetch unit. Issues one-cycle read
// requests to instruction memory, captures the returned word into an
// instruction register, and holds it for the decoder until accepted.
// Redirects (taken branches/jumps) flush any held or in-flight instruction.
// A wait counter flags a sticky error if memory takes too long to respond.
//
// Ports:
//   clk             in   clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   imem_req        out  one-cycle read request pulse
//   imem_addr       out  word-aligned request address (current pc)
//   imem_rvalid     in   read data valid
//   imem_rdata      in   read data
//   instr_valid     out  instr / instr_pc hold a fetched instruction
//   instr           out  instruction word (NOP when instr_valid is low)
//   instr_pc        out  address of instr
//   instr_ready     in   decoder accepts instr this cycle
//   redirect_valid  in   flush and refetch from redirect_pc
//   redirect_pc     in   new fetch address
//   fetch_err       out  sticky memory-response timeout flag
// -----------------------------------------------------------------------------
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_err
);

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT_CYCLES);

   fetch_state_e state_q;
   fetch_state_e state_d;
   logic [31:0]  ir_q;
   logic [31:0]  ir_d;
   logic [31:0]  ipc_q;
   logic [31:0]  ipc_d;
   logic [7:0]   cnt_q;
   logic [7:0]   cnt_d;
   logic         err_q;
   logic         err_d;
   logic         req_q;
   logic         valid_q;
   logic [31:0]  pc_s;
   logic         capture_s;
   logic         waiting_s;
   logic [7:0]   cnt_inc_s;

   // A response is kept only in WAIT and only if no redirect arrives with it.
   assign capture_s = (state_q == ST_WAIT) && imem_rvalid && !redirect_valid;
   assign waiting_s = (state_q == ST_WAIT) || (state_q == ST_DROP);
   assign cnt_inc_s = cnt_q + 8'd1;

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk           (clk),
      .rst_n         (rst_n),
      .redirect_i    (redirect_valid),
      .redirect_pc_i (redirect_pc),
      .incr_i        (capture_s),
      .pc_o          (pc_s)
   );

   // Next-state logic; redirect is evaluated first in every state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            // The request goes out this cycle regardless, so a redirect
            // must still wait for (and discard) its response.
            if (redirect_valid) begin
               state_d = ST_DROP;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (redirect_valid) begin
               state_d = imem_rvalid ? ST_FETCH : ST_DROP;
            end else if (imem_rvalid) begin
               state_d = ST_HOLD;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_HOLD: begin
            if (redirect_valid || instr_ready) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_DROP: begin
            if (imem_rvalid) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_DROP;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // Instruction register and its pc: loaded on capture, returned to NOP
   // when leaving HOLD so instr always shows NOP while nothing is valid.
   always_comb begin
      ir_d  = ir_q;
      ipc_d = ipc_q;
      if (capture_s) begin
         ir_d  = imem_rdata;
         ipc_d = pc_s;
      end else if ((state_q == ST_HOLD) && (state_d != ST_HOLD)) begin
         ir_d  = NOP_INSTR;
         ipc_d = ipc_q;
      end else begin
         ir_d  = ir_q;
         ipc_d = ipc_q;
      end
   end

   // Wait counter: cleared on any state change (which covers entry to
   // WAIT/DROP), counts while waiting, saturates at the limit. The error
   // flag rises in the same cycle the counter reaches the limit.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (state_d != state_q) begin
         cnt_d = 8'd0;
      end else if (waiting_s && (cnt_q != TIMEOUT_C)) begin
         cnt_d = cnt_inc_s;
         if (cnt_inc_s == TIMEOUT_C) begin
            err_d = 1'b1;
         end else begin
            err_d = err_q;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // FSM and output registers; req/valid are registered decodes of the
   // next state so they depend on memory inputs only through flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BOOT;
         ir_q    <= NOP_INSTR;
         ipc_q   <= 32'h0000_0000;
         cnt_q   <= 8'd0;
         err_q   <= 1'b0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         ipc_q   <= ipc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         req_q   <= (state_d == ST_FETCH);
         valid_q <= (state_d == ST_HOLD);
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_s;
   assign instr_valid = valid_q;
   assign instr       = ir_q;
   assign instr_pc    = ipc_q;
   assign fetch_err   = err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed self-checking bench for instruction_fetch. Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_err;

   int n_checks;
   int n_errors;

   instruction_fetch #(
      .RESET_PC       (32'h0000_1000),
      .TIMEOUT_CYCLES (255)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_err      (fetch_err)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called in a FETCH cycle: checks the request, returns data after lat
   // cycles, holds for hold_cycles with instr_ready low, then accepts.
   // Ends in the next FETCH cycle.
   task automatic fetch_txn(input logic [31:0] exp_addr, input int lat,
                            input logic [31:0] data, input int hold_cycles);
      check_val("req", 32'(imem_req), 32'd1);
      check_val("addr", imem_addr, exp_addr);
      instr_ready = 1'b0;
      imem_rvalid = 1'b0;
      for (int k = 1; k <= lat; k++) begin
         step();
         check_val("wait_valid", 32'(instr_valid), 32'd0);
         check_val("wait_req", 32'(imem_req), 32'd0);
         check_val("wait_instr", instr, NOP);
         if (k == lat) begin
            imem_rvalid = 1'b1;
            imem_rdata  = data;
         end
      end
      step();
      imem_rvalid = 1'b0;
      check_val("hold_valid", 32'(instr_valid), 32'd1);
      check_val("hold_instr", instr, data);
      check_val("hold_pc", instr_pc, exp_addr);
      for (int h = 0; h < hold_cycles; h++) begin
         step();
         check_val("stall_valid", 32'(instr_valid), 32'd1);
         check_val("stall_instr", instr, data);
         check_val("stall_pc", instr_pc, exp_addr);
         check_val("stall_req", 32'(imem_req), 32'd0);
      end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      check_val("next_req", 32'(imem_req), 32'd1);
      check_val("next_valid", 32'(instr_valid), 32'd0);
      check_val("next_instr", instr, NOP);
   endtask

   initial begin
      n_checks       = 0;
      n_errors       = 0;
      rst_n          = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = 32'h0000_0000;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0000_0000;

      // Reset state
      repeat (3) step();
      check_val("rst_req", 32'(imem_req), 32'd0);
      check_val("rst_valid", 32'(instr_valid), 32'd0);
      check_val("rst_addr", imem_addr, 32'h0000_1000);
      check_val("rst_instr", instr, NOP);
      check_val("rst_ipc", instr_pc, 32'h0000_0000);
      check_val("rst_err", 32'(fetch_err), 32'd0);

      // Release: one BOOT cycle, then FETCH at the reset pc
      rst_n = 1'b1;
      step();

      // Sequential fetch, latency 1, immediate accept
      fetch_txn(32'h0000_1000, 1, 32'hA000_0001, 0);
      fetch_txn(32'h0000_1004, 1, 32'hA000_0002, 0);

      // Decoder stall for 10 cycles in HOLD
      fetch_txn(32'h0000_1008, 2, 32'hB000_0003, 10);

      // Redirect during WAIT with latency 3: stale word discarded
      check_val("r1_addr", imem_addr, 32'h0000_100C);
      step();
      check_val("r1_wait_valid", 32'(instr_valid), 32'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_2002;
      step();
      redirect_valid = 1'b0;
      check_val("r1_drop_req", 32'(imem_req), 32'd0);
      check_val("r1_drop_addr", imem_addr, 32'h0000_2000);
      check_val("r1_drop_valid", 32'(instr_valid), 32'd0);
      step();
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      step();
      imem_rvalid = 1'b0;
      check_val("r1_fetch_valid", 32'(instr_valid), 32'd0);
      check_val("r1_fetch_instr", instr, NOP);
      fetch_txn(32'h0000_2000, 1, 32'hC000_0004, 0);

      // Redirect together with rvalid in WAIT: data dropped, straight to FETCH
      step();
      imem_rvalid    = 1'b1;
      imem_rdata     = 32'hBAD0_0001;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_3000;
      step();
      imem_rvalid    = 1'b0;
      redirect_valid = 1'b0;
      check_val("r2_req", 32'(imem_req), 32'd1);
      check_val("r2_addr", imem_addr, 32'h0000_3000);
      check_val("r2_valid", 32'(instr_valid), 32'd0);

      // Redirect in FETCH, two more in DROP, last one with rvalid
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_4000;
      step();
      check_val("r3_drop_req", 32'(imem_req), 32'd0);
      check_val("r3_drop_addr", imem_addr, 32'h0000_4000);
      redirect_pc = 32'h0000_5000;
      step();
      check_val("r3_drop_addr2", imem_addr, 32'h0000_5000);
      redirect_pc = 32'h0000_6004;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_0002;
      step();
      redirect_valid = 1'b0;
      imem_rvalid    = 1'b0;
      check_val("r3_valid", 32'(instr_valid), 32'd0);
      fetch_txn(32'h0000_6004, 1, 32'hD000_0005, 0);

      // Redirect in HOLD with instr_ready in the same cycle; also wrap check
      step();
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hE000_0006;
      step();
      imem_rvalid = 1'b0;
      check_val("r4_hold_valid", 32'(instr_valid), 32'd1);
      check_val("r4_hold_instr", instr, 32'hE000_0006);
      check_val("r4_hold_pc", instr_pc, 32'h0000_6008);
      instr_ready    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFF;
      step();
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      check_val("r4_valid", 32'(instr_valid), 32'd0);
      check_val("r4_instr", instr, NOP);
      fetch_txn(32'hFFFF_FFFC, 1, 32'hF000_0007, 0);
      check_val("wrap_addr", imem_addr, 32'h0000_0000);

      // Response timeout: error rises after 255 cycles in WAIT, stays set
      step();
      check_val("to_err_start", 32'(fetch_err), 32'd0);
      repeat (254) step();
      check_val("to_err_254", 32'(fetch_err), 32'd0);
      step();
      check_val("to_err_255", 32'(fetch_err), 32'd1);
      repeat (44) step();
      check_val("to_err_late", 32'(fetch_err), 32'd1);
      check_val("to_valid", 32'(instr_valid), 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h1234_5678;
      step();
      imem_rvalid = 1'b0;
      check_val("to_hold_instr", instr, 32'h1234_5678);
      check_val("to_hold_pc", instr_pc, 32'h0000_0000);
      check_val("to_hold_err", 32'(fetch_err), 32'd1);
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      check_val("to_next_addr", imem_addr, 32'h0000_0004);
      check_val("to_next_err", 32'(fetch_err), 32'd1);

      // Reset in WAIT; late rvalid in BOOT ignored
      step();
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_err", 32'(fetch_err), 32'd0);
      check_val("mid_rst_req", 32'(imem_req), 32'd0);
      check_val("mid_rst_addr", imem_addr, 32'h0000_1000);
      check_val("mid_rst_instr", instr, NOP);
      check_val("mid_rst_ipc", instr_pc, 32'h0000_0000);
      step();
      rst_n       = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_0003;
      step();
      imem_rvalid = 1'b0;
      check_val("boot_valid", 32'(instr_valid), 32'd0);
      fetch_txn(32'h0000_1000, 1, 32'h0ACE_0008, 0);
      check_val("final_addr", imem_addr, 32'h0000_1004);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
